// File: rtl/seq_pkg.sv
// Shared definitions for the 1011 pattern generator and its companion detector.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_t;

    localparam logic [3:0] SEQ_PATTERN_1011 = 4'b1011;

    // Detector states are named after the prefix of 1011 matched so far.
    typedef enum logic [2:0] {
        DET_S0    = 3'd0,
        DET_S1    = 3'd1,
        DET_S10   = 3'd2,
        DET_S101  = 3'd3,
        DET_S1011 = 3'd4
    } det_state_t;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control and serial-stream signals of the pattern transmitter.
interface seq_pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern_in;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             out_bit;
    logic             out_valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern_in, repeat_cnt, gap_len,
        input  out_bit, out_valid, frame_start, busy, done
    );

    modport slave (
        input  start, abort, pattern_in, repeat_cnt, gap_len,
        output out_bit, out_valid, frame_start, busy, done
    );
endinterface

// File: rtl/seq_shift_reg.sv
// Parallel-load, MSB-first shift register; the serial output is registered
// and returns to 0 on any cycle that neither loads nor shifts.
module seq_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_data,
    output logic         ser_out
);
    logic [W-1:0] data_reg;
    logic [W-1:0] load_shifted;
    logic [W-1:0] data_shifted;
    logic         ser_out_reg;

    // The MSB leaves on the load itself, so the register keeps the remainder.
    assign load_shifted[0] = 1'b0;
    assign data_shifted[0] = 1'b0;
    for (genvar gi = 1; gi < W; gi++) begin : g_chain
        assign load_shifted[gi] = load_data[gi-1];
        assign data_shifted[gi] = data_reg[gi-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_reg    <= '0;
            ser_out_reg <= 1'b0;
        end else if (load) begin
            data_reg    <= load_shifted;
            ser_out_reg <= load_data[W-1];
        end else if (shift) begin
            data_reg    <= data_shifted;
            ser_out_reg <= data_reg[W-1];
        end else begin
            ser_out_reg <= 1'b0;
        end
    end

    assign ser_out = ser_out_reg;
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: repeats a latched pattern MSB-first, with an
// optional idle gap between frames, under a start/busy/done handshake.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    seq_pattern_tx_if.slave bus
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    tx_state_t        state_reg, state_next;
    logic [PAT_W-1:0] pat_reg, pat_next;
    logic [CNT_W-1:0] frames_reg, frames_next;
    logic [GAP_W-1:0] gap_len_reg, gap_len_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             out_valid_reg, out_valid_next;
    logic             frame_start_reg, frame_start_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic             sr_load;
    logic             sr_shift;
    logic [PAT_W-1:0] sr_data;
    logic             sr_out;

    seq_shift_reg #(.W(PAT_W)) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (sr_data),
        .ser_out   (sr_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            pat_reg         <= '0;
            frames_reg      <= '0;
            gap_len_reg     <= '0;
            gap_cnt_reg     <= '0;
            idx_reg         <= '0;
            out_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pat_reg         <= pat_next;
            frames_reg      <= frames_next;
            gap_len_reg     <= gap_len_next;
            gap_cnt_reg     <= gap_cnt_next;
            idx_reg         <= idx_next;
            out_valid_reg   <= out_valid_next;
            frame_start_reg <= frame_start_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
        end
    end

    // frames_reg counts frames still to send after the one on the line,
    // so a full-scale repeat count never needs an extra counter bit.
    always_comb begin
        state_next       = state_reg;
        pat_next         = pat_reg;
        frames_next      = frames_reg;
        gap_len_next     = gap_len_reg;
        gap_cnt_next     = gap_cnt_reg;
        idx_next         = idx_reg;
        out_valid_next   = 1'b0;
        frame_start_next = 1'b0;
        busy_next        = 1'b0;
        done_next        = 1'b0;
        sr_load          = 1'b0;
        sr_shift         = 1'b0;
        sr_data          = pat_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    pat_next     = bus.pattern_in;
                    gap_len_next = bus.gap_len;
                    if (bus.repeat_cnt == '0) begin
                        frames_next = '0;
                        state_next  = ST_DONE;
                        done_next   = 1'b1;
                    end else begin
                        frames_next      = bus.repeat_cnt - CNT_W'(1);
                        idx_next         = IDX_MSB;
                        sr_load          = 1'b1;
                        sr_data          = bus.pattern_in;
                        state_next       = ST_SHIFT;
                        out_valid_next   = 1'b1;
                        frame_start_next = 1'b1;
                        busy_next        = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                busy_next = 1'b1;
                if (idx_reg != '0) begin
                    idx_next       = idx_reg - IDX_W'(1);
                    sr_shift       = 1'b1;
                    out_valid_next = 1'b1;
                end else if (frames_reg == '0) begin
                    state_next = ST_DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else if (gap_len_reg != '0) begin
                    state_next   = ST_GAP;
                    gap_cnt_next = gap_len_reg - GAP_W'(1);
                end else begin
                    frames_next      = frames_reg - CNT_W'(1);
                    idx_next         = IDX_MSB;
                    sr_load          = 1'b1;
                    out_valid_next   = 1'b1;
                    frame_start_next = 1'b1;
                end
            end
            ST_GAP: begin
                busy_next = 1'b1;
                if (gap_cnt_reg == '0) begin
                    frames_next      = frames_reg - CNT_W'(1);
                    idx_next         = IDX_MSB;
                    sr_load          = 1'b1;
                    state_next       = ST_SHIFT;
                    out_valid_next   = 1'b1;
                    frame_start_next = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (bus.abort && state_reg != ST_IDLE) begin
            state_next       = ST_IDLE;
            out_valid_next   = 1'b0;
            frame_start_next = 1'b0;
            busy_next        = 1'b0;
            done_next        = 1'b0;
            sr_load          = 1'b0;
            sr_shift         = 1'b0;
        end
    end

    assign bus.out_bit     = sr_out;
    assign bus.out_valid   = out_valid_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
endmodule
